normalizer_f: RTL and testbench

//  Normalizer for the fixed-point datapath. Inverse of the denormalizing y_f shifter.

---
 rtl/normalizer_f.sv | 107 ++++++++++
 tb/tb_normalizer_f.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/normalizer_f.sv
// Iterative normalizer: shifts a 23-bit magnitude left one bit per cycle
// until its MSB reaches the top, tracking a two's-complement exponent that
// counts down from +3 and stops at -12.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// NORM  | shifting work left and decrementing the exponent
// HOLD  | result presented with out_valid until out_ready
module normalizer_f #(
    parameter int MANT_W  = 20,
    parameter int EXP_MAX = 3,
    parameter int EXP_MIN = -12,
    parameter int EXP_W   = 5,
    parameter int IN_W    = MANT_W + EXP_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   ff_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] y_f_out,
    output logic [EXP_W-1:0]  exp_ff_out,
    output logic              zero,
    output logic              denorm,
    output logic              inexact
);

    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_BOT = EXP_W'(EXP_MIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IN_W-1:0]   work;
    logic [EXP_W-1:0]  e;
    logic              work_zero;
    logic              terminate;

    assign work_zero = (work == '0);
    // Stop on a normalized MSB, on the exponent floor, or when there is nothing to shift.
    assign terminate = work[IN_W-1] | (e == EXP_BOT) | work_zero;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = NORM;
            NORM:    if (terminate) state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift datapath and result registers; results hold until the next latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work       <= '0;
            e          <= '0;
            y_f_out    <= '0;
            exp_ff_out <= '0;
            zero       <= 1'b0;
            denorm     <= 1'b0;
            inexact    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= ff_in;
                        e    <= EXP_TOP;
                    end
                end
                NORM: begin
                    if (terminate) begin
                        y_f_out    <= work[IN_W-1 -: MANT_W];
                        exp_ff_out <= work_zero ? EXP_BOT : e;
                        inexact    <= |work[EXP_MAX-1:0];
                        zero       <= work_zero;
                        denorm     <= !work_zero && !work[IN_W-1];
                    end else begin
                        work <= work << 1;
                        e    <= e - EXP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalizer_f.sv
// Directed and random checks of normalizer_f with an expected-result queue.
module tb_normalizer_f;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] ff_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] y_f_out;
    logic [4:0]  exp_ff_out;
    logic        zero;
    logic        denorm;
    logic        inexact;

    typedef struct packed {
        logic [19:0] y;
        logic [4:0]  e;
        logic        z;
        logic        d;
        logic        i;
        logic [5:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    normalizer_f dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ff_in      (ff_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_f_out    (y_f_out),
        .exp_ff_out (exp_ff_out),
        .zero       (zero),
        .denorm     (denorm),
        .inexact    (inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [19:0] y, input logic [4:0] e,
                                input logic z, input logic d, input logic i, input int lat);
        exp_t r;
        r.y = y; r.e = e; r.z = z; r.d = d; r.i = i; r.lat = 6'(lat);
        return r;
    endfunction

    // Reference: locate the MSB, shift it to bit 22 (at most 15 places).
    function automatic exp_t model(input logic [22:0] v);
        exp_t        r;
        int          m;
        int          k;
        logic [22:0] s;
        r = '0;
        m = -1;
        for (int b = 0; b < 23; b++) if (v[b]) m = b;
        if (m < 0) begin
            r.e = 5'b10100; r.z = 1'b1; r.lat = 6'd1;
        end else begin
            k = 22 - m;
            if (k > 15) k = 15;
            s = v << k;
            r.y = s[22:3];
            r.e = 5'(3 - k);
            r.i = |s[2:0];
            r.d = ~s[22];
            r.lat = 6'(k + 1);
        end
        return r;
    endfunction

    task automatic start(input logic [22:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("start.in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        ff_in    = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ff_in    = 23'($urandom);
    endtask

    task automatic collect(input string tag);
        exp_t ex;
        int   lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s.queue: observed empty required entry", tag);
        end else begin
            ex = sb.pop_front();
            check({tag, ".latency"}, 32'(lat), 32'(ex.lat));
            check({tag, ".y_f_out"}, 32'(y_f_out), 32'(ex.y));
            check({tag, ".exp_ff_out"}, 32'(exp_ff_out), 32'(ex.e));
            check({tag, ".zero"}, 32'(zero), 32'(ex.z));
            check({tag, ".denorm"}, 32'(denorm), 32'(ex.d));
            check({tag, ".inexact"}, 32'(inexact), 32'(ex.i));
        end
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [22:0] v, input exp_t ex);
        sb.push_back(ex);
        start(v);
        collect(tag);
        release_out(tag);
    endtask

    initial begin
        exp_t        ex;
        logic [22:0] v;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ff_in = '0;
        #12;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.y_f_out", 32'(y_f_out), 32'd0);
        check("rst.exp_ff_out", 32'(exp_ff_out), 32'd0);
        check("rst.flags", 32'({zero, denorm, inexact}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("t1", 23'h400000, mk(20'h80000, 5'b00011, 1'b0, 1'b0, 1'b0, 1));
        run("t2", 23'h012345, mk(20'h91A28, 5'b11101, 1'b0, 1'b0, 1'b0, 7));
        run("t3a", 23'h000080, mk(20'h80000, 5'b10100, 1'b0, 1'b0, 1'b0, 16));
        run("t3b", 23'h000001, mk(20'h01000, 5'b10100, 1'b0, 1'b1, 1'b0, 16));
        run("t4a", 23'h000000, mk(20'h00000, 5'b10100, 1'b1, 1'b0, 1'b0, 1));
        run("t4b", 23'h400007, mk(20'h80000, 5'b00011, 1'b0, 1'b0, 1'b1, 1));

        // Backpressure: result must stay put and new requests must be ignored.
        v  = 23'h0ABCDE;
        ex = model(v);
        sb.push_back(ex);
        start(v);
        collect("t5");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ff_in    = 23'h7FFFFF;
            @(posedge clk);
            #1;
            check("t5.hold_valid", 32'(out_valid), 32'd1);
            check("t5.hold_in_ready", 32'(in_ready), 32'd0);
            check("t5.hold_y", 32'(y_f_out), 32'(ex.y));
            check("t5.hold_exp", 32'(exp_ff_out), 32'(ex.e));
        end
        in_valid = 1'b0;
        release_out("t5");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("t5.not_queued", 32'(out_valid), 32'd0);
        end

        // Reset in the middle of NORM.
        start(23'h000100);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6.rst_valid", 32'(out_valid), 32'd0);
        check("t6.rst_in_ready", 32'(in_ready), 32'd1);
        check("t6.rst_y", 32'(y_f_out), 32'd0);
        check("t6.rst_exp", 32'(exp_ff_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("t6", 23'h200000, mk(20'h80000, 5'b00010, 1'b0, 1'b0, 1'b0, 2));

        for (int n = 0; n < 300; n++) begin
            v = 23'($urandom) >> $urandom_range(0, 23);
            run("rnd", v, model(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
